// File: rtl/compress_and_return_if.sv
// rtl/compress_and_return_if.sv - USE slot inputs, take strobes and packed output word bundle
//
// Signals:
//   USEDataInput  [NUM][MAX*8]      element data per slot, byte k at [8k+7:8k]
//   USEByteCount  [NUM][clog2(MAX)] valid byte count per slot, 0 = empty
//   USEDataTaken  [NUM]             one-hot take strobe back to the sources
//   dataBus       [BW*8]            packed output word, lane 0 first in stream order
//   dataValid                       dataBus carries a new word this cycle
// Modports: master = sources/consumer side, slave = compress_and_return.
interface compress_and_return_if #(
  parameter int NUM_UNCOMPRESSED_ELEMENTS = 1,
  parameter int DATA_BUS_WIDTH_BYTES      = 8,
  parameter int MAX_STREAM_ELEMENT_LENGTH = 34
);
  localparam int CW = $clog2(MAX_STREAM_ELEMENT_LENGTH);

  logic [NUM_UNCOMPRESSED_ELEMENTS-1:0][MAX_STREAM_ELEMENT_LENGTH*8-1:0] USEDataInput;
  logic [NUM_UNCOMPRESSED_ELEMENTS-1:0][CW-1:0]                          USEByteCount;
  logic [NUM_UNCOMPRESSED_ELEMENTS-1:0]                                  USEDataTaken;
  logic [DATA_BUS_WIDTH_BYTES*8-1:0]                                     dataBus;
  logic                                                                  dataValid;

  modport master (
    output USEDataInput,
    output USEByteCount,
    input  USEDataTaken,
    input  dataBus,
    input  dataValid
  );

  modport slave (
    input  USEDataInput,
    input  USEByteCount,
    output USEDataTaken,
    output dataBus,
    output dataValid
  );
endinterface

// File: rtl/compress_and_return.sv
// rtl/compress_and_return.sv - packs length-prefixed USE records densely into output words
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    compress_and_return_if.slave: USE slot data/counts in, take strobes,
//          dataBus/dataValid out
// Each taken element becomes a record {L, data[0..L-1]} (L = count clamped to MAX)
// and records are laid back-to-back across output words with no padding.
module compress_and_return #(
  parameter int NUM_UNCOMPRESSED_ELEMENTS = 1,
  parameter int DATA_BUS_WIDTH_BYTES      = 8,
  parameter int MAX_STREAM_ELEMENT_LENGTH = 34,
  parameter int IDLE_FLUSH_CYCLES         = 8
) (
  input logic                  clk,
  input logic                  reset,
  compress_and_return_if.slave bus
);
  localparam int NUM = NUM_UNCOMPRESSED_ELEMENTS;
  localparam int BW  = DATA_BUS_WIDTH_BYTES;
  localparam int MAX = MAX_STREAM_ELEMENT_LENGTH;
  localparam int SB  = MAX + 1;                      // staging bytes: header + data
  localparam int CW  = $clog2(MAX);
  localparam int RW  = $clog2(MAX + 2);
  localparam int FW  = $clog2(BW);
  localparam int PW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int IW  = $clog2(IDLE_FLUSH_CYCLES + 1);

  logic [SB*8-1:0] stage;   // front of the record currently draining sits in byte 0
  logic [RW-1:0]   rem;
  logic [FW-1:0]   fill;    // lanes already occupied in the partial word
  logic [BW*8-1:0] part;    // lanes at or above fill are kept zero
  logic [PW-1:0]   ptr;
  logic [IW-1:0]   idle;

  int              r_i, rem_i, free_i, n_i, ptr_i, sel_i, l_i;
  logic            found, take, flush;
  logic [CW-1:0]   cnt_sel;
  logic [MAX*8-1:0] dat_sel;
  logic [SB*8-1:0] stage_load, stage_shift;
  logic [BW*8-1:0] ins, part_next;

  always_comb begin
    r_i         = int'(fill);
    rem_i       = int'(rem);
    ptr_i       = int'(ptr);
    free_i      = BW - r_i;
    n_i         = (rem_i < free_i) ? rem_i : free_i;
    found       = 1'b0;
    sel_i       = 0;
    cnt_sel     = '0;
    dat_sel     = '0;
    stage_load  = '0;
    part_next   = part;
    bus.USEDataTaken = '0;

    // Round-robin: first non-empty slot at or after ptr, then wrap to the lower slots.
    for (int i = 0; i < NUM; i++) begin
      if (!found && i >= ptr_i && bus.USEByteCount[i] != '0) begin
        found = 1'b1;
        sel_i = i;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!found && i < ptr_i && bus.USEByteCount[i] != '0) begin
        found = 1'b1;
        sel_i = i;
      end
    end

    // A new record may be loaded once the current one finishes draining on this edge.
    take = reset && found && (rem_i == 0 || rem_i <= free_i);

    for (int i = 0; i < NUM; i++) begin
      if (i == sel_i) begin
        cnt_sel = bus.USEByteCount[i];
        dat_sel = bus.USEDataInput[i];
        bus.USEDataTaken[i] = take;
      end
    end

    l_i = int'(cnt_sel);
    if (l_i > MAX) l_i = MAX;
    stage_load[7:0] = 8'(l_i);
    for (int k = 0; k < MAX; k++) begin
      if (k < l_i) stage_load[(k+1)*8 +: 8] = dat_sel[k*8 +: 8];
    end

    stage_shift = stage >> (8 * n_i);

    // Stage front bytes land at lanes fill..fill+n-1 of the partial word.
    ins = stage[BW*8-1:0] << (8 * r_i);
    for (int j = 0; j < BW; j++) begin
      if (j >= r_i && j < r_i + n_i) part_next[j*8 +: 8] = ins[j*8 +: 8];
    end

    flush = (rem_i == 0) && (r_i != 0) && !take &&
            (int'(idle) + 1 >= IDLE_FLUSH_CYCLES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage         <= '0;
      rem           <= '0;
      fill          <= '0;
      part          <= '0;
      ptr           <= '0;
      idle          <= '0;
      bus.dataBus   <= '0;
      bus.dataValid <= 1'b0;
    end else begin
      bus.dataValid <= 1'b0;

      if (take) begin
        stage <= stage_load;
        rem   <= RW'(l_i + 1);
        ptr   <= (sel_i + 1 >= NUM) ? '0 : PW'(sel_i + 1);
      end else if (rem_i > 0) begin
        stage <= stage_shift;
        rem   <= RW'(rem_i - n_i);
      end

      if (rem_i > 0) begin
        if (r_i + n_i == BW) begin
          bus.dataBus   <= part_next;
          bus.dataValid <= 1'b1;
          fill          <= '0;
          part          <= '0;
        end else begin
          fill <= FW'(r_i + n_i);
          part <= part_next;
        end
      end else if (flush) begin
        // Unused upper lanes are already zero, giving the end-of-stream header.
        bus.dataBus   <= part;
        bus.dataValid <= 1'b1;
        fill          <= '0;
        part          <= '0;
      end

      if (take) begin
        idle <= '0;
      end else if (rem_i == 0 && r_i != 0) begin
        idle <= flush ? '0 : idle + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_compress_and_return.sv
// tb/tb_compress_and_return.sv - self-checking bench for compress_and_return
module tb_compress_and_return;
  localparam int NUM  = 3;
  localparam int BW   = 8;
  localparam int MAX  = 34;
  localparam int IDLE = 8;
  localparam int CW   = $clog2(MAX);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  compress_and_return_if #(
    .NUM_UNCOMPRESSED_ELEMENTS(NUM),
    .DATA_BUS_WIDTH_BYTES(BW),
    .MAX_STREAM_ELEMENT_LENGTH(MAX)
  ) bus ();

  compress_and_return #(
    .NUM_UNCOMPRESSED_ELEMENTS(NUM),
    .DATA_BUS_WIDTH_BYTES(BW),
    .MAX_STREAM_ELEMENT_LENGTH(MAX),
    .IDLE_FLUSH_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    int               slot;
    int               len;
    int               at;
    logic [MAX*8-1:0] d;
  } elem_t;

  elem_t            pend[$];
  logic [MAX*8-1:0] sdata [NUM];
  int               slen [NUM];
  int               load_cyc [NUM];
  logic [7:0]       exp_q[$];
  logic [BW*8-1:0]  word_log[$];
  int               word_edge[$];
  int               take_slot[$];
  int               take_edge[$];
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  int               max_delay = 0;

  function automatic logic [MAX*8-1:0] seq_data(input int base);
    logic [MAX*8-1:0] d;
    for (int k = 0; k < MAX; k++) d[k*8 +: 8] = 8'(base + k);
    return d;
  endfunction

  function automatic logic [MAX*8-1:0] rnd_data();
    logic [MAX*8-1:0] d;
    for (int k = 0; k < MAX; k++) d[k*8 +: 8] = 8'($urandom);
    return d;
  endfunction

  function automatic bit busy();
    bit b;
    b = (pend.size() > 0) || (exp_q.size() > 0);
    for (int i = 0; i < NUM; i++) if (slen[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < NUM; i++) begin
      bus.USEDataInput[i] = sdata[i];
      bus.USEByteCount[i] = CW'(slen[i]);
    end
  endtask

  task automatic add_elem(input int slot, input int len, input int at, input logic [MAX*8-1:0] d);
    elem_t e;
    e.slot = slot; e.len = len; e.at = at; e.d = d;
    pend.push_back(e);
  endtask

  // One clock: sample at the falling edge, then update the sources just after the rising edge.
  task automatic tick();
    logic [NUM-1:0]  tk;
    logic [BW*8-1:0] w;
    elem_t           keep[$];
    tk = '0;
    @(negedge clk);
    if (reset) begin
      if (bus.dataValid) begin
        total++;
        w = '0;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_word: got %h, required no word (edge %0d)", bus.dataBus, cyc);
        end else begin
          for (int k = 0; k < BW; k++) if (exp_q.size() > 0) w[k*8 +: 8] = exp_q.pop_front();
          if (bus.dataBus !== w) begin
            bad++;
            $display("FAIL word: got %h required %h (edge %0d)", bus.dataBus, w, cyc);
          end
        end
        word_log.push_back(bus.dataBus);
        word_edge.push_back(cyc);
      end
      tk = bus.USEDataTaken;
      if (tk != '0) begin
        total++;
        if ($countones(tk) != 1) begin
          bad++;
          $display("FAIL onehot: taken=%b required a single bit", tk);
        end
      end
      for (int i = 0; i < NUM; i++) begin
        if (tk[i]) begin
          int l;
          total++;
          if (slen[i] == 0) begin
            bad++;
            $display("FAIL take_empty: slot %0d taken with count=0, required no take", i);
          end
          l = (slen[i] > MAX) ? MAX : slen[i];
          if (l > 0) begin
            exp_q.push_back(8'(l));
            for (int k = 0; k < l; k++) exp_q.push_back(sdata[i][k*8 +: 8]);
          end
          take_slot.push_back(i);
          take_edge.push_back(cyc + 1);
          if (cyc - load_cyc[i] > max_delay) max_delay = cyc - load_cyc[i];
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM; i++) if (tk[i]) slen[i] = 0;
    for (int j = 0; j < pend.size(); j++) begin
      if (pend[j].at <= cyc && slen[pend[j].slot] == 0) begin
        slen[pend[j].slot]     = pend[j].len;
        sdata[pend[j].slot]    = pend[j].d;
        load_cyc[pend[j].slot] = cyc;
      end else begin
        keep.push_back(pend[j]);
      end
    end
    pend = keep;
    drive_slots();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 800) begin
      tick();
      n++;
    end
    repeat (IDLE + 4) tick();
    total++;
    if (exp_q.size() != 0 || n >= 800) begin
      bad++;
      $display("FAIL %s_drain: %0d bytes still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    pend.delete();
    exp_q.delete();
    for (int i = 0; i < NUM; i++) slen[i] = 0;
    drive_slots();
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    slen[0]  = 5;
    sdata[0] = seq_data(40);
    drive_slots();
    for (int c = 0; c < 3; c++) begin
      tick();
      total += 3;
      if (bus.dataValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", bus.dataValid); end
      if (bus.dataBus !== '0) begin bad++; $display("FAIL reset_bus: got %h required 0", bus.dataBus); end
      if (bus.USEDataTaken !== '0) begin bad++; $display("FAIL reset_taken: got %b required 0", bus.USEDataTaken); end
    end
    slen[0] = 0;
    drive_slots();
    reset = 1'b1;
    repeat (4) tick();
    total++;
    if (bus.dataValid !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got %b required 0", bus.dataValid); end
  endtask

  task automatic test_single_30();
    int s, ts;
    logic [BW*8-1:0] w;
    s = word_log.size(); ts = take_slot.size();
    add_elem(0, 30, cyc, seq_data(0));
    drain("single");
    total++;
    if (word_log.size() - s != 4 || take_slot.size() - ts != 1) begin
      bad++;
      $display("FAIL single_counts: words=%0d takes=%0d required 4 and 1", word_log.size() - s, take_slot.size() - ts);
    end else begin
      for (int wi = 0; wi < 4; wi++) begin
        for (int k = 0; k < BW; k++) begin
          int b;
          b = wi * BW + k;
          w[k*8 +: 8] = (b == 0) ? 8'd30 : (b <= 30 ? 8'(b - 1) : 8'd0);
        end
        total++;
        if (word_log[s+wi] !== w) begin bad++; $display("FAIL single_word%0d: got %h required %h", wi, word_log[s+wi], w); end
      end
      total += 2;
      if (word_edge[s] - take_edge[ts] != 1) begin
        bad++; $display("FAIL single_latency: got %0d edges required 1", word_edge[s] - take_edge[ts]);
      end
      if (word_edge[s+3] - take_edge[ts] != 12) begin
        bad++; $display("FAIL single_flush_time: got %0d edges required 12", word_edge[s+3] - take_edge[ts]);
      end
    end
  endtask

  task automatic test_two_records();
    int s;
    logic [BW*8-1:0] w3, w4;
    s = word_log.size();
    add_elem(0, 30, cyc, seq_data(0));
    add_elem(0, 31, cyc + 5, seq_data(0));
    drain("two");
    for (int k = 0; k < BW; k++) begin
      w3[k*8 +: 8] = (k == 7) ? 8'd31 : 8'(23 + k);
      w4[k*8 +: 8] = 8'(k);
    end
    total++;
    if (word_log.size() - s != 8) begin
      bad++; $display("FAIL two_count: got %0d words required 8", word_log.size() - s);
    end else begin
      total += 2;
      if (word_log[s+3] !== w3) begin bad++; $display("FAIL two_word3: got %h required %h", word_log[s+3], w3); end
      if (word_log[s+4] !== w4) begin bad++; $display("FAIL two_word4: got %h required %h", word_log[s+4], w4); end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    s = word_log.size();
    max_delay = 0;
    for (int e = 0; e < 10; e++) add_elem(0, 34, cyc + 5 * e, rnd_data());
    drain("b2b");
    total += 2;
    if (word_log.size() - s != 44) begin bad++; $display("FAIL b2b_words: got %0d required 44", word_log.size() - s); end
    if (max_delay > 4) begin bad++; $display("FAIL b2b_take_delay: got %0d cycles required <=4", max_delay); end
  endtask

  task automatic test_reference_20();
    int lens[10] = '{30, 31, 17, 23, 19, 31, 30, 28, 21, 31};
    int s;
    s = word_log.size();
    for (int e = 0; e < 20; e++) add_elem(0, lens[e % 10], cyc, rnd_data());
    drain("ref20");
    total++;
    if (word_log.size() - s != 68) begin
      bad++; $display("FAIL ref20_words: got %0d required 68", word_log.size() - s);
    end else begin
      total++;
      if (word_log[s+67][63:48] !== 16'h0) begin
        bad++; $display("FAIL ref20_tail_lanes: got %h required 0000", word_log[s+67][63:48]);
      end
    end
  endtask

  task automatic test_round_robin();
    int s, ts;
    apply_reset();
    s = word_log.size(); ts = take_slot.size();
    add_elem(0, 10, cyc, rnd_data());
    add_elem(1, 20, cyc, rnd_data());
    add_elem(2, 50, cyc, rnd_data());
    drain("rr");
    total += 2;
    if (word_log.size() - s != 9) begin bad++; $display("FAIL rr_words: got %0d required 9", word_log.size() - s); end
    if (take_slot.size() - ts != 3) begin
      bad++; $display("FAIL rr_takes: got %0d required 3", take_slot.size() - ts);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (take_slot[ts+k] != k) begin bad++; $display("FAIL rr_order%0d: got slot %0d required %0d", k, take_slot[ts+k], k); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    add_elem(0, 34, cyc, rnd_data());
    repeat (3) tick();
    reset = 1'b0;
    pend.delete();
    exp_q.delete();
    slen[0]  = 17;
    sdata[0] = rnd_data();
    drive_slots();
    #1;
    total += 3;
    if (bus.dataValid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b required 0", bus.dataValid); end
    if (bus.dataBus !== '0) begin bad++; $display("FAIL mid_reset_bus: got %h required 0", bus.dataBus); end
    if (bus.USEDataTaken !== '0) begin bad++; $display("FAIL mid_reset_taken: got %b required 0", bus.USEDataTaken); end
    repeat (2) tick();
    total++;
    if (bus.dataValid !== 1'b0 || bus.USEDataTaken !== '0) begin
      bad++; $display("FAIL mid_reset_hold: valid=%b taken=%b required 0", bus.dataValid, bus.USEDataTaken);
    end
    s = word_log.size();
    load_cyc[0] = cyc;
    reset = 1'b1;
    drain("mid");
    total++;
    if (word_log.size() - s != 3) begin
      bad++; $display("FAIL mid_words: got %0d required 3", word_log.size() - s);
    end else begin
      total++;
      if (word_log[s][7:0] !== 8'd17) begin bad++; $display("FAIL mid_header: got %0d required 17", word_log[s][7:0]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      slen[i] = 0; sdata[i] = '0; load_cyc[i] = 0;
    end
    drive_slots();
    test_reset();
    test_single_30();
    test_two_records();
    test_back_to_back();
    test_reference_20();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
